// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and a device port.
// Optional DMEM_ARB_DEV_READONLY_EN: device writes are accepted but dropped and flagged.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_wEn,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_dataIn,
    output logic [DATA_WIDTH-1:0] cpu_dataOut,
    output logic                  cpu_stall,
    input  logic                  dev_req,
    input  logic                  dev_wEn,
    input  logic [ADDR_WIDTH-1:0] dev_addr,
    input  logic [DATA_WIDTH-1:0] dev_dataIn,
    output logic                  dev_gnt,
    output logic                  dev_valid,
    output logic [DATA_WIDTH-1:0] dev_dataOut,
    output logic                  dev_err,
    output logic                  ram_wEn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_dataIn,
    input  logic [DATA_WIDTH-1:0] ram_dataOut
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       force_gnt;
    logic       dev_own;
    logic       dev_wr_ok;

    assign cpu_dataOut = ram_dataOut;
    assign dev_dataOut = ram_dataOut;

`ifdef DMEM_ARB_DEV_READONLY_EN
    assign dev_wr_ok = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            dev_err <= 1'b0;
        end else if (dev_gnt && dev_wEn) begin
            dev_err <= 1'b1;
        end
    end
`else
    assign dev_wr_ok = dev_wEn;
    assign dev_err   = 1'b0;
`endif

    // The CPU keeps the port unless the device has waited MAX_WAIT cycles.
    always_comb begin
        force_gnt  = dev_req && (wait_cnt == WAIT_LIM);
        dev_own    = !reset && dev_req && (!cpu_req || force_gnt);
        dev_gnt    = dev_own;
        cpu_stall  = !reset && cpu_req && force_gnt;
        ram_addr   = cpu_addr;
        ram_dataIn = cpu_dataIn;
        ram_wEn    = !reset && cpu_req && cpu_wEn;
        if (dev_own) begin
            ram_addr   = dev_addr;
            ram_dataIn = dev_dataIn;
            ram_wEn    = dev_wr_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            dev_valid <= 1'b0;
        end else begin
            if (dev_gnt || !dev_req) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            dev_valid <= dev_gnt && !dev_wEn;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter
// against a cycle-level reference model with its own memory image.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MAX_WAIT = 8;
    localparam int DEPTH = 1 << AW;
`ifdef DMEM_ARB_DEV_READONLY_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          cpu_req;
    logic          cpu_wEn;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dataIn;
    logic [DW-1:0] cpu_dataOut;
    logic          cpu_stall;
    logic          dev_req;
    logic          dev_wEn;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_dataIn;
    logic          dev_gnt;
    logic          dev_valid;
    logic [DW-1:0] dev_dataOut;
    logic          dev_err;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;

    dmem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wEn    (cpu_wEn),
        .cpu_addr   (cpu_addr),
        .cpu_dataIn (cpu_dataIn),
        .cpu_dataOut(cpu_dataOut),
        .cpu_stall  (cpu_stall),
        .dev_req    (dev_req),
        .dev_wEn    (dev_wEn),
        .dev_addr   (dev_addr),
        .dev_dataIn (dev_dataIn),
        .dev_gnt    (dev_gnt),
        .dev_valid  (dev_valid),
        .dev_dataOut(dev_dataOut),
        .dev_err    (dev_err),
        .ram_wEn    (ram_wEn),
        .ram_addr   (ram_addr),
        .ram_dataIn (ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM instance stand-in: read-first, one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        ram_dataOut <= mem[ram_addr];
        if (ram_wEn) mem[ram_addr] = ram_dataIn;
    end

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_wait;
    logic          m_valid;
    logic [DW-1:0] m_vdata;
    logic          m_cpu_rd;
    logic [DW-1:0] m_cdata;
    logic          m_err;
    logic          last_gnt;
    logic          last_stall;

    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // check one cycle against the model, then advance the model across the edge
    task automatic cyc();
        logic          frc, eg, es, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, rdv;
        #1;
        frc = dev_req && (m_wait == MAX_WAIT);
        eg  = !reset && dev_req && (!cpu_req || frc);
        es  = !reset && cpu_req && frc;
        ea  = eg ? dev_addr : cpu_addr;
        ed  = eg ? dev_dataIn : cpu_dataIn;
        ew  = !reset && (eg ? (dev_wEn && !RO) : (cpu_req && cpu_wEn));
        chk("dev_gnt", 32'(dev_gnt), 32'(eg));
        chk("cpu_stall", 32'(cpu_stall), 32'(es));
        chk("ram_wEn", 32'(ram_wEn), 32'(ew));
        chk("dev_valid", 32'(dev_valid), 32'(m_valid));
        chk("dev_err", 32'(dev_err), 32'(m_err));
        if (!reset && (cpu_req || dev_req)) chk("ram_addr", 32'(ram_addr), 32'(ea));
        if (ew) chk("ram_dataIn", ram_dataIn, ed);
        if (m_valid) chk("dev_dataOut", dev_dataOut, m_vdata);
        if (m_cpu_rd) chk("cpu_dataOut", cpu_dataOut, m_cdata);
        rdv      = ref_mem[ea];
        m_valid  = eg && !dev_wEn;
        m_vdata  = rdv;
        m_cpu_rd = !reset && cpu_req && !eg && !cpu_wEn;
        m_cdata  = rdv;
        if (ew) ref_mem[ea] = ed;
        if (reset) begin
            m_wait   = 0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            m_cpu_rd = 1'b0;
        end else begin
            if (eg && dev_wEn && RO) m_err = 1'b1;
            if (eg || !dev_req) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
        last_gnt   = eg;
        last_stall = es;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cpu_drv(input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_wEn = w; cpu_addr = a; cpu_dataIn = d;
    endtask

    task automatic dev_drv(input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        dev_req = r; dev_wEn = w; dev_addr = a; dev_dataIn = d;
    endtask

    initial begin
        logic [31:0] mask;
        int          bad;
        logic [DW-1:0] keep40;
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = mem[i];
        end
        mem[12'h020]     = 32'h1234_5678;
        ref_mem[12'h020] = 32'h1234_5678;
        m_wait = 0; m_valid = 0; m_vdata = '0; m_err = 0;
        m_cpu_rd = 0; m_cdata = '0; last_gnt = 0; last_stall = 0;
        reset = 1'b1;
        cpu_drv(1'b1, 1'b1, 12'h7FF, 32'hBAD0_BAD0);
        dev_drv(1'b1, 1'b1, 12'h7FE, 32'hBAD1_BAD1);
        @(negedge clock);
        cyc();
        cyc();
        reset = 1'b0;
        cpu_drv(1'b0, 1'b0, '0, '0);
        dev_drv(1'b0, 1'b0, '0, '0);
        cyc();

        // CPU store then load, device idle
        cpu_drv(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
        cyc();
        cpu_drv(1'b1, 1'b0, 12'h010, '0);
        cyc();
        cpu_drv(1'b0, 1'b0, '0, '0);
        cyc();
        chk("sw_mem_010", mem[12'h010], 32'hDEAD_BEEF);

        // device read with CPU idle
        dev_drv(1'b1, 1'b0, 12'h020, '0);
        cyc();
        dev_drv(1'b0, 1'b0, '0, '0);
        chk("dev_valid_after_read", 32'(dev_valid), 32'd1);
        chk("dev_data_after_read", dev_dataOut, 32'h1234_5678);
        cyc();

        // continuous contention: one forced slot every MAX_WAIT+1 cycles
        mask = '0;
        for (int i = 0; i < 27; i++) begin
            cpu_drv(1'b1, 1'b0, 12'(12'h100 + i), '0);
            dev_drv(1'b1, 1'b0, 12'(12'h200 + i), '0);
            if (i > 0 && last_stall) cpu_drv(1'b1, 1'b0, cpu_addr, '0);
            #1;
            mask[i] = dev_gnt;
            cyc();
        end
        chk("contention_pattern", mask, 32'h0402_0100);
        cpu_drv(1'b0, 1'b0, '0, '0);
        dev_drv(1'b0, 1'b0, '0, '0);
        cyc();

        // CPU store collides with a forced device store to the same word
        dev_drv(1'b1, 1'b1, 12'h030, 32'h2);
        for (int i = 0; i < MAX_WAIT; i++) begin
            cpu_drv(1'b1, 1'b0, 12'h031, '0);
            cyc();
        end
        cpu_drv(1'b1, 1'b1, 12'h030, 32'h1);
        #1;
        chk("collide_stall", 32'(cpu_stall), 32'd1);
        cyc();
        dev_drv(1'b0, 1'b0, '0, '0);
        if (!RO) chk("collide_dev_first", mem[12'h030], 32'h2);
        cyc();
        cpu_drv(1'b0, 1'b0, '0, '0);
        chk("collide_final", mem[12'h030], 32'h1);
        cyc();

        // device read granted, reset on the following edge
        dev_drv(1'b1, 1'b0, 12'h020, '0);
        cyc();
        reset = 1'b1;
        cpu_drv(1'b1, 1'b1, 12'h050, 32'h5555_5555);
        cyc();
        reset = 1'b0;
        cpu_drv(1'b0, 1'b0, '0, '0);
        dev_drv(1'b0, 1'b0, '0, '0);
        chk("valid_after_reset", 32'(dev_valid), 32'd0);
        chk("mem_050_untouched", mem[12'h050], ref_mem[12'h050]);
        cyc();

        // device write to 0x040; dropped and flagged in the read-only build
        keep40 = mem[12'h040];
        dev_drv(1'b1, 1'b1, 12'h040, 32'hFF);
        cyc();
        dev_drv(1'b0, 1'b0, '0, '0);
        chk("mem_040", mem[12'h040], RO ? keep40 : 32'hFF);
        chk("dev_err_set", 32'(dev_err), 32'(RO));
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("dev_err_cleared", 32'(dev_err), 32'd0);
        cyc();

        // random traffic obeying both handshakes
        for (int i = 0; i < 600; i++) begin
            if (!(dev_req && !last_gnt)) begin
                dev_drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        12'($urandom_range(0, 31)), $urandom);
            end
            if (!last_stall) begin
                cpu_drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        12'($urandom_range(0, 31)), $urandom);
            end
            reset = ($urandom_range(0, 60) == 0);
            cyc();
        end
        reset = 1'b0;
        cpu_drv(1'b0, 1'b0, '0, '0);
        dev_drv(1'b0, 1'b0, '0, '0);
        cyc();

        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        chk("final_mem_image", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
